dacchannel: RTL and testbench

- Output-direction counterpart of the ADC channel path. Drives an external 8-bit parallel DAC (dac_clk plus dac_data) from a 32-entry waveform buffer that is loaded over the 8-bit wishbone register bus.
- Playback runs once or in a loop. It starts immediately or is armed to start on the ADC trigger (sq_trigger).
- Sits beside the ADC channels on the same wishbone decoder. Used for calibration stimulus and function-generator output.

---
 rtl/dacchannel_pkg.sv | 27 ++
 rtl/dacchannel_clkgen.sv | 37 +++
 rtl/dacchannel.sv | 183 ++++++++++++++++++
 tb/tb_dacchannel.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dacchannel_pkg.sv
// Shared definitions for the DAC playback channel: register map,
// CTRL/CMD bit positions and the playback state encoding.
package dacchannel_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_HOLD   = 3'd1;
    localparam logic [2:0] REG_DIV    = 3'd2;
    localparam logic [2:0] REG_LEN    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_CMD    = 3'd5;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_LOOP = 1;
    localparam int CTRL_TRIG = 2;
    localparam int CTRL_RAMP = 3;

    localparam int CMD_START = 0;
    localparam int CMD_ABORT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dacchannel_clkgen.sv
// DAC latch clock divider: half-period of DIV+1 cycles, with an update
// strobe coincident with every falling edge of dac_clk.
module dacclkgen (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] div,
    input  logic       div_wr,
    output logic       dac_clk,
    output logic       strobe
);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap   = enable && !div_wr && (cnt == div);
    // Data changes on the falling edge so it is settled by the next rise.
    assign strobe = wrap && dac_clk;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            dac_clk <= 1'b0;
        end else if (!enable) begin
            cnt     <= '0;
            dac_clk <= 1'b0;
        end else if (div_wr) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt     <= '0;
            dac_clk <= !dac_clk;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dacchannel.sv
// DAC waveform playback channel with wishbone-loaded buffer.
// Optional ramp generator mode: define DACCHANNEL_RAMP_EN.
module dacchannel
    import dacchannel_pkg::*;
#(
    parameter int WAVE_DEPTH   = 32,
    parameter int ADDR_BIT_RAM = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sq_trigger,
    output logic        dac_clk,
    output logic [7:0]  dac_data,
    output logic        dac_busy,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    output logic [7:0]  wb_dat_o,
    output logic        wb_ack_o
);

    localparam int IW = $clog2(WAVE_DEPTH);
`ifdef DACCHANNEL_RAMP_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    logic [7:0]    ram [WAVE_DEPTH];
    logic [3:0]    ctrl;
    logic [7:0]    hold;
    logic [7:0]    div;
    logic [IW-1:0] len;
    logic [7:0]    rd_data;
    logic [7:0]    idx_wide;
    logic          acc, wr, reg_wr, sel_ram;
    logic          start, abort, div_wr, strobe;
    logic [IW-1:0] ram_a;
    logic [2:0]    reg_a;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    data_d;
    logic          ramp_mode;
`ifdef DACCHANNEL_RAMP_EN
    logic [7:0]    ramp_q, ramp_d;
    assign ramp_mode = ctrl[CTRL_RAMP];
`else
    assign ramp_mode = 1'b0;
`endif

    assign acc     = wb_stb_i && wb_cyc_i && !wb_ack_o;
    assign wr      = acc && wb_we_i;
    assign sel_ram = wb_adr_i[ADDR_BIT_RAM];
    assign ram_a   = wb_adr_i[IW-1:0];
    assign reg_a   = wb_adr_i[2:0];
    assign reg_wr  = wr && !sel_ram;
    assign start   = reg_wr && (reg_a == REG_CMD) && wb_dat_i[CMD_START];
    assign abort   = reg_wr && (reg_a == REG_CMD) && wb_dat_i[CMD_ABORT];
    assign div_wr  = reg_wr && (reg_a == REG_DIV);
    assign idx_wide = 8'(idx_q);
    assign dac_busy = (state_q == ST_PLAY);

    dacclkgen u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .enable  (ctrl[CTRL_EN]),
        .div     (div),
        .div_wr  (div_wr),
        .dac_clk (dac_clk),
        .strobe  (strobe)
    );

    always_comb begin
        rd_data = '0;
        if (sel_ram) begin
            rd_data = ram[ram_a];
        end else begin
            case (reg_a)
                REG_CTRL:   rd_data = {4'd0, ctrl};
                REG_HOLD:   rd_data = hold;
                REG_DIV:    rd_data = div;
                REG_LEN:    rd_data = 8'(len);
                REG_STATUS: rd_data = {idx_wide[4:0], 1'b0, state_q};
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            ctrl     <= '0;
            hold     <= '0;
            div      <= '0;
            len      <= '0;
        end else begin
            wb_ack_o <= acc;
            if (acc) wb_dat_o <= rd_data;
            if (reg_wr) begin
                case (reg_a)
                    REG_CTRL: ctrl <= wb_dat_i[3:0] & CTRL_MASK;
                    REG_HOLD: hold <= wb_dat_i;
                    REG_DIV:  div  <= wb_dat_i;
                    REG_LEN:  len  <= wb_dat_i[IW-1:0];
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr && sel_ram) ram[ram_a] <= wb_dat_i;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = dac_data;
`ifdef DACCHANNEL_RAMP_EN
        ramp_d  = ramp_q;
`endif
        if (strobe) begin
            if (state_q != ST_PLAY) begin
                data_d = hold;
            end else if (ramp_mode) begin
`ifdef DACCHANNEL_RAMP_EN
                data_d = ramp_q;
                ramp_d = ramp_q + hold;
`endif
            end else begin
                data_d = ram[idx_q];
                if (idx_q == len) begin
                    if (ctrl[CTRL_LOOP]) idx_d = '0;
                    else state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
        if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            if (ctrl[CTRL_TRIG]) begin
                state_d = ST_ARMED;
            end else begin
                state_d = ST_PLAY;
                idx_d   = '0;
`ifdef DACCHANNEL_RAMP_EN
                ramp_d  = '0;
`endif
            end
        end
        if (state_q == ST_ARMED && sq_trigger) begin
            state_d = ST_PLAY;
            idx_d   = '0;
`ifdef DACCHANNEL_RAMP_EN
            ramp_d  = '0;
`endif
        end
        // Abort beats start; the code chosen by this strobe is still driven.
        if (abort || !ctrl[CTRL_EN]) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dac_data <= '0;
`ifdef DACCHANNEL_RAMP_EN
            ramp_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dac_data <= data_d;
`ifdef DACCHANNEL_RAMP_EN
            ramp_q   <= ramp_d;
`endif
        end
    end

endmodule

// File: tb/tb_dacchannel.sv
// Directed self-checking bench for dacchannel: register table plus
// hand-written playback, trigger, abort and reset sequences.
module tb_dacchannel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sq_trigger = 1'b0;
    logic        dac_clk;
    logic [7:0]  dac_data;
    logic        dac_busy;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [15:0] wb_adr_i = '0;
    logic [7:0]  wb_dat_i = '0;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [7:0]  dat;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[$];

`ifdef DACCHANNEL_RAMP_EN
    localparam logic [7:0] CTRL_RB = 8'h0F;
`else
    localparam logic [7:0] CTRL_RB = 8'h07;
`endif

    dacchannel dut (
        .clk        (clk),
        .rst        (rst),
        .sq_trigger (sq_trigger),
        .dac_clk    (dac_clk),
        .dac_data   (dac_data),
        .dac_busy   (dac_busy),
        .wb_stb_i   (wb_stb_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [15:0] adr,
                        input logic [7:0] dat, input logic trig,
                        output logic [7:0] rdat);
        @(negedge clk);
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_we_i = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        sq_trigger = trig;
        @(negedge clk);
        check("ack", {31'd0, wb_ack_o}, 32'd1);
        rdat = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i = 1'b0;
        sq_trigger = 1'b0;
    endtask

    task automatic wr(input logic [15:0] adr, input logic [7:0] dat);
        logic [7:0] d;
        xfer(1'b1, adr, dat, 1'b0, d);
    endtask

    task automatic rd(input logic [15:0] adr, output logic [7:0] d);
        xfer(1'b0, adr, 8'h00, 1'b0, d);
    endtask

    // Called at a negedge; returns at the negedge sample showing the next fall.
    task automatic wait_fall(output logic ok);
        logic p;
        p = dac_clk;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (p && !dac_clk) begin
                ok = 1'b1;
                break;
            end
            p = dac_clk;
        end
        if (!ok) check("fall_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_fall(input string name, input logic [7:0] exp);
        logic ok;
        wait_fall(ok);
        if (ok) check(name, {24'd0, dac_data}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] d;
        logic       ok;
        logic       p;
        logic [7:0] last;
        int         n;
        int         acks;

        repeat (3) @(negedge clk);
        check("rst_dac_clk", {31'd0, dac_clk}, 32'd0);
        check("rst_dac_data", {24'd0, dac_data}, 32'd0);
        check("rst_busy", {31'd0, dac_busy}, 32'd0);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat_o", {24'd0, wb_dat_o}, 32'd0);
        rst = 1'b0;

        tbl.push_back('{1'b1, 16'h0002, 8'h03, 8'h00});
        tbl.push_back('{1'b0, 16'h0002, 8'h00, 8'h03});
        tbl.push_back('{1'b1, 16'h0001, 8'hA5, 8'h00});
        tbl.push_back('{1'b0, 16'h0001, 8'h00, 8'hA5});
        tbl.push_back('{1'b1, 16'h0003, 8'hFF, 8'h00});
        tbl.push_back('{1'b0, 16'h0003, 8'h00, 8'h1F});
        tbl.push_back('{1'b1, 16'h0000, 8'hFF, 8'h00});
        tbl.push_back('{1'b0, 16'h0000, 8'h00, CTRL_RB});
        tbl.push_back('{1'b1, 16'h0000, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 16'h0000, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 16'h0004, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 16'h0023, 8'h77, 8'h00});
        tbl.push_back('{1'b0, 16'h0023, 8'h00, 8'h77});
        tbl.push_back('{1'b1, 16'h003F, 8'h99, 8'h00});
        tbl.push_back('{1'b0, 16'h013F, 8'h00, 8'h99});
        tbl.push_back('{1'b0, 16'h0005, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 16'h0006, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 16'h0007, 8'h00, 8'h00});

        foreach (tbl[i]) begin
            xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, 1'b0, d);
            if (!tbl[i].we)
                check($sformatf("reg_vec[%0d]", i), {24'd0, d},
                      {24'd0, tbl[i].exp});
        end

        // Held strobe: ack every other cycle.
        @(negedge clk);
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_adr_i = 16'h0001;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        check("held_stb_acks", acks, 3);

        // Clock generation with DIV=1.
        wr(16'h0002, 8'h01);
        wr(16'h0001, 8'h5A);
        wr(16'h0000, 8'h01);
        expect_fall("hold_on_strobe", 8'h5A);
        for (int k = 0; k < 3; k++) begin
            p = dac_clk;
            last = dac_data;
            n = 0;
            ok = 1'b0;
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                n++;
                if (!p && dac_clk)
                    check("stable_at_rise", {24'd0, dac_data}, {24'd0, last});
                if (p && !dac_clk) begin
                    ok = 1'b1;
                    break;
                end
                p = dac_clk;
                last = dac_data;
            end
            check("period", n, 4);
        end

        // One-shot playback of four entries.
        wr(16'h0020, 8'd10);
        wr(16'h0021, 8'd20);
        wr(16'h0022, 8'd30);
        wr(16'h0023, 8'd40);
        wr(16'h0003, 8'h03);
        wr(16'h0005, 8'h01);
        expect_fall("oneshot_0", 8'd10);
        check("busy_play", {31'd0, dac_busy}, 32'd1);
        expect_fall("oneshot_1", 8'd20);
        expect_fall("oneshot_2", 8'd30);
        expect_fall("oneshot_3", 8'd40);
        check("busy_done", {31'd0, dac_busy}, 32'd0);
        rd(16'h0004, d);
        check("status_done", {24'd0, d}, 32'h1B);
        expect_fall("oneshot_hold", 8'h5A);

        // Triggered loop over two entries.
        wr(16'h0020, 8'd0);
        wr(16'h0021, 8'd1);
        wr(16'h0003, 8'h01);
        wr(16'h0000, 8'h07);
        wr(16'h0005, 8'h01);
        rd(16'h0004, d);
        check("armed_state", {30'd0, d[1:0]}, 32'd1);
        expect_fall("armed_hold", 8'h5A);
        check("armed_busy", {31'd0, dac_busy}, 32'd0);
        @(negedge clk);
        sq_trigger = 1'b1;
        @(negedge clk);
        sq_trigger = 1'b0;
        expect_fall("loop_0", 8'd0);
        expect_fall("loop_1", 8'd1);
        expect_fall("loop_2", 8'd0);
        expect_fall("loop_3", 8'd1);
        wr(16'h0005, 8'h02);
        rd(16'h0004, d);
        check("abort_state", {30'd0, d[1:0]}, 32'd0);
        expect_fall("abort_hold", 8'h5A);

        // Start and abort in the same byte.
        wr(16'h0000, 8'h01);
        wr(16'h0005, 8'h03);
        rd(16'h0004, d);
        check("start_abort", {30'd0, d[1:0]}, 32'd0);
        check("start_abort_busy", {31'd0, dac_busy}, 32'd0);

        // Trigger coincident with the start write is ignored.
        wr(16'h0000, 8'h05);
        xfer(1'b1, 16'h0005, 8'h01, 1'b1, d);
        rd(16'h0004, d);
        check("trig_with_start", {30'd0, d[1:0]}, 32'd1);
        wr(16'h0005, 8'h02);

        // LEN=0 plays only entry 0.
        wr(16'h0000, 8'h01);
        wr(16'h0020, 8'hC3);
        wr(16'h0003, 8'h00);
        wr(16'h0005, 8'h01);
        expect_fall("len0_entry", 8'hC3);
        check("len0_busy", {31'd0, dac_busy}, 32'd0);
        rd(16'h0004, d);
        check("len0_state", {30'd0, d[1:0]}, 32'd3);
        expect_fall("len0_hold", 8'h5A);

        // Reset in the middle of looped playback.
        wr(16'h0000, 8'h03);
        wr(16'h0003, 8'h03);
        wr(16'h0005, 8'h01);
        expect_fall("pre_reset", 8'hC3);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_clk", {31'd0, dac_clk}, 32'd0);
        check("mid_rst_data", {24'd0, dac_data}, 32'd0);
        check("mid_rst_busy", {31'd0, dac_busy}, 32'd0);
        check("mid_rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("mid_rst_dat_o", {24'd0, wb_dat_o}, 32'd0);
        rst = 1'b0;
        rd(16'h0004, d);
        check("post_rst_status", {24'd0, d}, 32'd0);
        rd(16'h0000, d);
        check("post_rst_ctrl", {24'd0, d}, 32'd0);

`ifdef DACCHANNEL_RAMP_EN
        wr(16'h0002, 8'h01);
        wr(16'h0001, 8'h40);
        wr(16'h0000, 8'h09);
        wr(16'h0005, 8'h01);
        expect_fall("ramp_0", 8'h00);
        expect_fall("ramp_1", 8'h40);
        expect_fall("ramp_2", 8'h80);
        expect_fall("ramp_3", 8'hC0);
        expect_fall("ramp_4", 8'h00);
        check("ramp_busy", {31'd0, dac_busy}, 32'd1);
        wr(16'h0005, 8'h02);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
